// File: rtl/inst_prefetch_queue_if.sv
// Fetch/decode-side bundle of the instruction prefetch queue.
// The master modport is the fetch unit plus decoder; the slave modport is the queue itself.
interface inst_prefetch_queue_if #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int POP_MAX = 3
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                      push_valid;
  logic [DATA_W-1:0]         push_data;
  logic                      push_ready;
  logic [1:0]                pop_len;
  logic [POP_MAX*DATA_W-1:0] peek_data;
  logic [POP_MAX-1:0]        peek_valid;
  logic [CW-1:0]             queue_count;
  logic                      fetch_req;
  logic                      pop_err;

  modport master (
    output push_valid, push_data, pop_len,
    input  push_ready, peek_data, peek_valid, queue_count, fetch_req, pop_err
  );

  modport slave (
    input  push_valid, push_data, pop_len,
    output push_ready, peek_data, peek_valid, queue_count, fetch_req, pop_err
  );
endinterface

// File: rtl/inst_prefetch_queue.sv
// Circular byte FIFO between fetch and decode: one push per cycle, a POP_MAX-byte peek window,
// and a variable-length retire of up to POP_MAX bytes per cycle. Flushed by a taken branch.
module inst_prefetch_queue #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int POP_MAX   = 3,
  parameter int FETCH_LWM = 4
) (
  input  logic                  queue_clk,
  input  logic                  queue_reset_n,
  input  logic                  queue_flush,
  inst_prefetch_queue_if.slave  q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] POP_MAX_C = CW'(POP_MAX);
  localparam logic [CW-1:0] LWM_C     = CW'(FETCH_LWM);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic              pop_err_q;

  logic              push_acc;
  logic [CW-1:0]     pop_len_ext;
  logic              pop_nz;
  logic              pop_legal;
  logic              pop_illegal;
  logic [AW-1:0]     peek_idx;

  assign q.push_ready  = queue_reset_n & (count != DEPTH_C);
  assign q.queue_count = count;
  assign q.fetch_req   = queue_reset_n & ~queue_flush & ((DEPTH_C - count) >= LWM_C);
  assign q.pop_err     = pop_err_q;

  assign push_acc    = q.push_valid & q.push_ready & ~queue_flush;
  assign pop_len_ext = CW'(q.pop_len);
  assign pop_nz      = (pop_len_ext != '0);
  assign pop_legal   = pop_nz && (pop_len_ext <= POP_MAX_C) && (pop_len_ext <= count);
  assign pop_illegal = pop_nz && !pop_legal;

  // Window slots beyond the current occupancy read as zero so decode never sees stale bytes.
  always_comb begin
    q.peek_data  = '0;
    q.peek_valid = '0;
    peek_idx     = '0;
    for (int i = 0; i < POP_MAX; i++) begin
      peek_idx = rd_ptr + AW'(i);
      if (CW'(i) < count) begin
        q.peek_valid[i]                = 1'b1;
        q.peek_data[i*DATA_W +: DATA_W] = mem[peek_idx];
      end
    end
  end

  always_ff @(posedge queue_clk) begin
    if (!queue_reset_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      pop_err_q <= 1'b0;
    end else if (queue_flush) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      pop_err_q <= 1'b0;
    end else begin
      if (push_acc)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop_legal)
        rd_ptr <= rd_ptr + AW'(q.pop_len);
      count     <= count + CW'(push_acc) - (pop_legal ? pop_len_ext : '0);
      pop_err_q <= pop_illegal;
    end
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge queue_clk) begin
    if (push_acc)
      mem[wr_ptr] <= q.push_data;
  end
endmodule
